// File: rtl/twi_frame_formatter.sv
// rtl/twi_frame_formatter.sv - buffers captured TWI frames and renders each as an ASCII line for a byte UART.
// Optional TWI_FMT_SPACE_EN inserts spaces between fields (13-char line instead of 9).
module twi_frame_formatter #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_valid,
  input  logic [17:0]      frame,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef TWI_FMT_SPACE_EN
  localparam int LINE_LEN = 13;
`else
  localparam int LINE_LEN = 9;
`endif
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GUARD, WAIT} state_t;

  state_t           state_q, state_d;
  logic [17:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [17:0]      line;
  logic [3:0]       char_idx;
  logic [7:0]       cur_char;
  logic             full, empty, pop, push, drop, fire, advance;

  assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty = (fifo_level == '0);
  assign pop   = (state_q == LOAD);
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign push  = frame_valid & enable & (~full | pop);
  assign drop  = frame_valid & enable & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= frame;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  logic [7:0] addr8, data8, rw_ch, ack1_ch, ack2_ch;
  assign addr8   = {1'b0, line[17:11]};
  assign data8   = line[8:1];
  assign rw_ch   = line[10] ? 8'h52 : 8'h57;
  assign ack1_ch = line[9]  ? 8'h4E : 8'h41;
  assign ack2_ch = line[0]  ? 8'h4E : 8'h41;

  always_comb begin
    cur_char = 8'h00;
    case (char_idx)
`ifdef TWI_FMT_SPACE_EN
      4'd0:  cur_char = hex_char(addr8[7:4]);
      4'd1:  cur_char = hex_char(addr8[3:0]);
      4'd2:  cur_char = 8'h20;
      4'd3:  cur_char = rw_ch;
      4'd4:  cur_char = 8'h20;
      4'd5:  cur_char = ack1_ch;
      4'd6:  cur_char = 8'h20;
      4'd7:  cur_char = hex_char(data8[7:4]);
      4'd8:  cur_char = hex_char(data8[3:0]);
      4'd9:  cur_char = 8'h20;
      4'd10: cur_char = ack2_ch;
      4'd11: cur_char = 8'h0D;
      4'd12: cur_char = 8'h0A;
`else
      4'd0:  cur_char = hex_char(addr8[7:4]);
      4'd1:  cur_char = hex_char(addr8[3:0]);
      4'd2:  cur_char = rw_ch;
      4'd3:  cur_char = ack1_ch;
      4'd4:  cur_char = hex_char(data8[7:4]);
      4'd5:  cur_char = hex_char(data8[3:0]);
      4'd6:  cur_char = ack2_ch;
      4'd7:  cur_char = 8'h0D;
      4'd8:  cur_char = 8'h0A;
`endif
      default: cur_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // GUARD gives the UART one cycle to raise busy after the start pulse.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE:  if (!empty) state_d = LOAD;
      LOAD:  state_d = SEND;
      SEND:  if (!tx_busy) begin
               fire    = 1'b1;
               state_d = GUARD;
             end
      GUARD: state_d = WAIT;
      WAIT:  if (!tx_busy) begin
               if (char_idx == LAST_IDX) state_d = IDLE;
               else begin
                 advance = 1'b1;
                 state_d = SEND;
               end
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      line     <= '0;
      char_idx <= '0;
    end else begin
      tx_start <= fire;
      if (fire) tx_data <= cur_char;
      if (pop) begin
        line     <= mem[rd_ptr];
        char_idx <= '0;
      end else if (advance) begin
        char_idx <= char_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_twi_frame_formatter.sv
// tb/tb_twi_frame_formatter.sv - scoreboard bench: text-line reference model, UART busy model, random bursts.
module tb_twi_frame_formatter;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 0;
  logic             reset = 0;
  logic             enable = 1;
  logic             frame_valid = 0;
  logic [17:0]      frame = '0;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             clear_overflow = 0;

  twi_frame_formatter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
    .frame(frame), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  bit ov_exp = 0;
  bit hold = 0;
  bit rand_busy = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for a number of cycles after each start pulse.
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= rand_busy ? int'($urandom_range(1, 10)) : 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold | (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  function automatic void expect_line(input logic [17:0] f);
    logic [7:0] a, d;
    a = {1'b0, f[17:11]};
    d = f[8:1];
    exp_q.push_back(hx(a[7:4]));
    exp_q.push_back(hx(a[3:0]));
`ifdef TWI_FMT_SPACE_EN
    exp_q.push_back(" ");
`endif
    exp_q.push_back(f[10] ? "R" : "W");
`ifdef TWI_FMT_SPACE_EN
    exp_q.push_back(" ");
`endif
    exp_q.push_back(f[9] ? "N" : "A");
`ifdef TWI_FMT_SPACE_EN
    exp_q.push_back(" ");
`endif
    exp_q.push_back(hx(d[7:4]));
    exp_q.push_back(hx(d[3:0]));
`ifdef TWI_FMT_SPACE_EN
    exp_q.push_back(" ");
`endif
    exp_q.push_back(f[0] ? "N" : "A");
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  always @(negedge clk) begin
    if (reset && tx_start) begin
      chk("start_while_busy", {31'b0, tx_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_char: got %02h expected none", tx_data);
      end else begin
        chk("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_frame(input logic [17:0] f, input bit en);
    @(negedge clk);
    frame = f; enable = en; frame_valid = 1;
    @(negedge clk);
    frame_valid = 0;
  endtask

  task automatic wait_start(output int at);
    int n = 0;
    while (!tx_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    if (!tx_start) begin
      checks++;
      failures++;
      $display("FAIL wait_start: got timeout expected tx_start");
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    n = 0;
    while (tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("level_after_drain", 32'(fifo_level), 0);
  endtask

  // While the UART is stalled the block holds one line plus DEPTH queued frames.
  task automatic burst(input int n, input bit rand_en, input bit rand_clr);
    int nen = 0;
    int lvl;
    logic [17:0] f;
    bit en, clr;
    @(negedge clk);
    hold = 1;
    for (int i = 0; i < n; i++) begin
      f = 18'($urandom);
      en = rand_en ? ($urandom_range(0, 4) != 0) : 1'b1;
      clr = rand_clr ? ($urandom_range(0, 3) == 0) : 1'b0;
      frame = f; enable = en; frame_valid = 1; clear_overflow = clr;
      if (en) begin
        nen++;
        if (nen <= DEPTH + 1) expect_line(f);
      end
      if (en && nen > DEPTH + 1) ov_exp = 1;
      else if (clr) ov_exp = 0;
      @(negedge clk);
    end
    frame_valid = 0; clear_overflow = 0; enable = 1;
    repeat (2) @(negedge clk);
    lvl = (nen == 0) ? 0 : ((nen < DEPTH + 1 ? nen : DEPTH + 1) - 1);
    chk("burst_level", 32'(fifo_level), lvl);
    chk("burst_overflow", {31'b0, overflow}, {31'b0, ov_exp});
    if (ov_exp) begin
      clear_overflow = 1;
      @(negedge clk);
      clear_overflow = 0;
      ov_exp = 0;
      chk("overflow_cleared", {31'b0, overflow}, 32'd0);
    end
    hold = 0;
    drain();
  endtask

  initial begin
    int c0, c1, starts;
    logic [17:0] f1, f2;
    f1 = {7'h3C, 1'b0, 1'b0, 8'hA5, 1'b1};
    f2 = {7'h7F, 1'b1, 1'b1, 8'h00, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_tx_start", {31'b0, tx_start}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    expect_line(f1);
    push_frame(f1, 1);
    c0 = cyc;
    wait_start(c1);
    chk("first_latency", c1 - c0, 3);
    drain();

    expect_line(f2);
    push_frame(f2, 1);
    drain();

    for (int i = 0; i < 3; i++) push_frame(18'($urandom), 0);
    repeat (4) @(negedge clk);
    chk("disabled_level", 32'(fifo_level), 0);
    chk("disabled_overflow", {31'b0, overflow}, 0);

    burst(6, 0, 0);

    expect_line(f1);
    push_frame(f1, 1);
    wait_start(c1);
    push_frame(18'($urandom), 0);
    drain();
    chk("midline_enable_overflow", {31'b0, overflow}, 0);

    rand_busy = 1;
    for (int k = 0; k < 12; k++) burst(int'($urandom_range(1, 8)), 1, 1);
    rand_busy = 0;

    burst(7, 0, 0);
    @(negedge clk);
    hold = 1;
    for (int i = 0; i < 7; i++) begin
      f1 = 18'($urandom);
      if (i < DEPTH + 1) expect_line(f1);
      frame = f1; enable = 1; frame_valid = 1;
      @(negedge clk);
    end
    frame_valid = 0;
    @(negedge clk);
    hold = 0;
    wait_start(c1);
    #2 reset = 0;
    #1;
    chk("async_rst_tx_start", {31'b0, tx_start}, 0);
    chk("async_rst_tx_data", {24'b0, tx_data}, 0);
    chk("async_rst_level", 32'(fifo_level), 0);
    chk("async_rst_overflow", {31'b0, overflow}, 0);
    exp_q.delete();
    ov_exp = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("quiet_after_reset", starts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twi_frame_formatter.md
Name: twi_frame_formatter

Overview:
Downstream consumer of captured 18-bit TWI frames {addr[6:0], rw, ack1, data[7:0], ack2}. Buffers frames in a small FIFO so back-to-back bus traffic is not lost while the UART is busy. Renders each frame as an ASCII text line and drives the byte-wide UART transmitter handshake (start pulse / busy), one character at a time. Sits between the frame capture shift register and async_transmitter, replacing direct raw-byte presentation.

Parameters:
FIFO_DEPTH, 4, frame FIFO entries; power of two, >= 2.
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
enable  in  1  accept new frames when 1; a line already in progress always completes
frame_valid  in  1  single-cycle strobe: frame holds a complete capture
frame  in  18  bit17..11 addr, bit10 rw (1=R), bit9 ack1 (0=ACK), bit8..1 data, bit0 ack2 (0=ACK)
tx_busy  in  1  UART busy
tx_start  out  1  one-cycle pulse: tx_data is valid to transmit
tx_data  out  8  ASCII character
fifo_level  out  LVL_W  frames currently buffered
overflow  out  1  sticky: at least one frame dropped
clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers 0, fifo_level=0, overflow=0, tx_start=0, tx_data=8'h00, FSM=IDLE.
- Push: frame_valid & enable & !full -> write frame, level+1 at next edge. frame_valid & enable & full -> frame dropped, overflow<=1. frame_valid & !enable -> ignored, no overflow.
- Simultaneous push and pop: level unchanged; allowed when full (pop frees the slot in the same cycle, push accepted).
- clear_overflow & drop in the same cycle: overflow stays 1 (set wins).
- Line format (base, 9 chars): hex({1'b0,addr}) 2 chars, 'R'/'W', 'A'/'N' (ack1), hex(data) 2 chars, 'A'/'N' (ack2), 8'h0D, 8'h0A.
- Hex: nibble 0-9 -> 8'h30+n, A-F -> 8'h41+(n-10); uppercase, MSN first.
- FSM: IDLE -> (fifo not empty) LOAD: pop head into a line register, char_idx=0 -> SEND: when tx_busy=0, drive tx_data=char[char_idx], tx_start=1 for exactly one cycle -> GUARD: one cycle, tx_start=0, ignores tx_busy (covers UART busy latency) -> WAIT: when tx_busy=0, if char_idx is last -> IDLE, else char_idx+1 -> SEND.
- Latency: frame pushed into an empty FIFO with UART idle -> first tx_start 3 cycles after the frame_valid edge (push, LOAD, SEND).
- tx_data holds its value between pulses; it only changes in SEND.
- Line register is independent of the FIFO; new pushes during a line never corrupt it.
- enable deasserted mid-line: the line finishes, queued frames still drain; only new pushes are blocked.
- Pointers wrap modulo FIFO_DEPTH; full = (level==FIFO_DEPTH), empty = (level==0).

Optional Feature:
TWI_FMT_SPACE_EN: when defined, one ASCII space (8'h20) follows the address, the R/W char, the ack1 char and the data field, giving a 13-char line ("3C W A A5 N\r\n"). When undefined, the 9-char packed format is used. FSM and handshake are unchanged; only the character table and last-index value differ.

Test Plan:
- Reset: drive reset=0 mid-line -> tx_start=0, tx_data=00, fifo_level=0, overflow=0 immediately; after release no characters are sent until a frame arrives.
- Single frame: frame={7'h3C,0,0,8'hA5,1}, tx_busy model 10 cycles -> exact sequence 33 43 57 41 41 35 4E 0D 0A; one tx_start per char, never while tx_busy=1; first tx_start 3 cycles after frame_valid.
- Read/NACK mapping: frame={7'h7F,1,1,8'h00,0} -> 37 46 52 4E 30 30 41 0D 0A.
- Burst/overflow: FIFO_DEPTH=4, 6 frames pushed 1 cycle apart while the UART is busy -> frames 1-5 transmitted in order (one in line register plus 4 queued), frame 6 dropped, overflow=1; clear_overflow -> 0.
- Enable gating: enable=0 with frame_valid pulses -> no pushes, overflow stays 0; enable dropped mid-line -> the current line completes fully.
- With TWI_FMT_SPACE_EN: first frame above -> 33 43 20 57 20 41 20 41 35 20 4E 0D 0A.
